// File: rtl/cache_refill_if.sv
// Bundle of the core, cache and memory-side signals of cache_refill_ctrl.
// Signal names keep the controller's point of view: *_i are driven into the
// controller and *_o are driven by it.
//   core_*  : request/response with the core
//   cache_* : lookup port and refill write port of the two-way cache
//   mem_*   : valid/ready request and response to the next memory level
//   *_count : saturating hit/miss statistics
// master = controller side, slave = environment (core, cache, memory).
interface cache_refill_if #(
  parameter int BLOCK_SIZE = 32,
  parameter int CNT_W      = 16
);
  logic                  core_req_v_i;
  logic [31:0]           core_addr_i;
  logic                  core_ready_o;
  logic                  core_resp_v_o;
  logic [BLOCK_SIZE-1:0] core_resp_data_o;
  logic                  cache_rd_en_o;
  logic [31:0]           cache_rd_addr_o;
  logic                  cache_rd_valid_i;
  logic                  cache_miss_i;
  logic [BLOCK_SIZE-1:0] cache_rd_data_i;
  logic                  cache_wr_en_o;
  logic [31:0]           cache_wr_addr_o;
  logic [BLOCK_SIZE-1:0] cache_wr_data_o;
  logic                  mem_req_v_o;
  logic [31:0]           mem_req_addr_o;
  logic                  mem_req_ready_i;
  logic                  mem_resp_v_i;
  logic [BLOCK_SIZE-1:0] mem_resp_data_i;
  logic [CNT_W-1:0]      hit_count_o;
  logic [CNT_W-1:0]      miss_count_o;

  modport master (
    input  core_req_v_i, core_addr_i,
           cache_rd_valid_i, cache_miss_i, cache_rd_data_i,
           mem_req_ready_i, mem_resp_v_i, mem_resp_data_i,
    output core_ready_o, core_resp_v_o, core_resp_data_o,
           cache_rd_en_o, cache_rd_addr_o,
           cache_wr_en_o, cache_wr_addr_o, cache_wr_data_o,
           mem_req_v_o, mem_req_addr_o,
           hit_count_o, miss_count_o
  );

  modport slave (
    output core_req_v_i, core_addr_i,
           cache_rd_valid_i, cache_miss_i, cache_rd_data_i,
           mem_req_ready_i, mem_resp_v_i, mem_resp_data_i,
    input  core_ready_o, core_resp_v_o, core_resp_data_o,
           cache_rd_en_o, cache_rd_addr_o,
           cache_wr_en_o, cache_wr_addr_o, cache_wr_data_o,
           mem_req_v_o, mem_req_addr_o,
           hit_count_o, miss_count_o
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding-request refill controller between a core and a
// two-way cache. A request is looked up in the cache; a hit returns the
// cached block, a miss fetches the block from memory, writes it into the
// cache and returns it to the core.
// Ports:
//   clk_i   : single clock, rising edge
//   reset_i : synchronous, active-high reset
//   bus     : cache_refill_if.master (core, cache and memory signals,
//             hit/miss statistics counters)
// All outputs are decoded from registered state/data only.
module cache_refill_ctrl #(
  parameter int BLOCK_SIZE = 32,
  parameter int CNT_W      = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  cache_refill_if.master bus
);
  localparam int          OFFSET_W   = $clog2(BLOCK_SIZE / 8);
  // Clears the byte-offset bits; all ones when a block is a single byte.
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_REQ, MEM_WAIT, REFILL, RESP
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] data_q, data_d;
  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    bus.core_ready_o     = 1'b0;
    bus.core_resp_v_o    = 1'b0;
    bus.core_resp_data_o = '0;
    bus.cache_rd_en_o    = 1'b0;
    bus.cache_rd_addr_o  = '0;
    bus.cache_wr_en_o    = 1'b0;
    bus.cache_wr_addr_o  = '0;
    bus.cache_wr_data_o  = '0;
    bus.mem_req_v_o      = 1'b0;
    bus.mem_req_addr_o   = '0;
    bus.hit_count_o      = hit_cnt_q;
    bus.miss_count_o     = miss_cnt_q;

    case (state_q)
      IDLE: begin
        bus.core_ready_o = 1'b1;
        if (bus.core_req_v_i) begin
          addr_d  = bus.core_addr_i & ALIGN_MASK;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.cache_rd_en_o   = 1'b1;
        bus.cache_rd_addr_o = addr_q;
        // A hit wins over a simultaneous miss; neither means re-issue.
        if (bus.cache_rd_valid_i) begin
          data_d    = bus.cache_rd_data_i;
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = RESP;
        end else if (bus.cache_miss_i) begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          state_d    = MEM_REQ;
        end
      end
      MEM_REQ: begin
        bus.mem_req_v_o    = 1'b1;
        bus.mem_req_addr_o = addr_q;
        if (bus.mem_req_ready_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_resp_v_i) begin
          data_d  = bus.mem_resp_data_i;
          state_d = REFILL;
        end
      end
      REFILL: begin
        bus.cache_wr_en_o   = 1'b1;
        bus.cache_wr_addr_o = addr_q;
        bus.cache_wr_data_o = data_q;
        state_d             = RESP;
      end
      RESP: begin
        bus.core_resp_v_o    = 1'b1;
        bus.core_resp_data_o = data_q;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized scoreboard bench for cache_refill_ctrl (BLOCK_SIZE=32, CNT_W=2).
// The driver decides each transaction's outcome at a transaction level
// (hit/miss, stall counts, memory data) and pushes the expected memory
// request, cache write and core response; a monitor pops and compares.
module tb_cache_refill_ctrl;
  localparam int BS   = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  cache_refill_if #(.BLOCK_SIZE(BS), .CNT_W(CW)) bus ();
  cache_refill_ctrl #(.BLOCK_SIZE(BS), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(bus));

  typedef struct { logic [31:0] data; int cyc; int hits; int misses; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  resp_t       exp_resp[$];
  wr_t         exp_wr[$];
  logic [31:0] exp_maddr[$];

  logic [31:0] cache_m [logic [31:0]];
  logic [31:0] memory_m[logic [31:0]];

  int n_checks = 0, n_pass = 0, n_drv_fail = 0;
  int cyc = 0;
  int m_hits = 0, m_misses = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction plan read by the environment responders.
  bit          p_hit = 0, p_spur = 0;
  int          p_stalls = 0, p_rd = 0, p_sd = 0;
  logic [31:0] p_hdata = '0, p_mdata = '0;

  // Cache and memory responders: drive inputs on the falling edge.
  int lk_cnt = 0, rq_cnt = 0, wt_cnt = 0;
  bit mwait = 0;
  initial begin
    bus.cache_rd_valid_i = 0; bus.cache_miss_i = 0; bus.cache_rd_data_i = '0;
    bus.mem_req_ready_i = 0; bus.mem_resp_v_i = 0; bus.mem_resp_data_i = '0;
  end
  always @(negedge clk) begin
    bus.cache_rd_valid_i = 0; bus.cache_miss_i = 0; bus.cache_rd_data_i = $urandom;
    bus.mem_req_ready_i = 0; bus.mem_resp_v_i = 0; bus.mem_resp_data_i = $urandom;
    if (bus.cache_rd_en_o) begin
      if (lk_cnt >= p_stalls) begin
        if (p_hit) begin
          bus.cache_rd_valid_i = 1; bus.cache_miss_i = 1'($urandom % 2);
          bus.cache_rd_data_i = p_hdata;
        end else bus.cache_miss_i = 1;
      end
      lk_cnt++;
    end else lk_cnt = 0;
    if (bus.mem_req_v_o) begin
      if (rq_cnt >= p_rd) begin
        bus.mem_req_ready_i = 1; mwait = 1; wt_cnt = 0;
      end else if (p_spur) bus.mem_resp_v_i = 1;
      rq_cnt++;
    end else begin
      rq_cnt = 0;
      if (mwait) begin
        if (wt_cnt == p_sd) begin
          bus.mem_resp_v_i = 1; bus.mem_resp_data_i = p_mdata; mwait = 0;
        end else wt_cnt++;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, req);
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  bit rst_prev = 0, mreq_pend = 0, chk_ready = 0;
  logic [31:0] maddr_prev = '0;
  always @(negedge clk) begin
    resp_t r; wr_t w; logic [31:0] ea;
    #1;
    if (rst_prev) begin
      check("reset_ready", 32'(bus.core_ready_o), 1);
      check("reset_ctrl_outs", {28'd0, bus.cache_rd_en_o, bus.cache_wr_en_o,
            bus.mem_req_v_o, bus.core_resp_v_o}, 0);
      check("reset_data_outs", bus.cache_rd_addr_o | bus.cache_wr_addr_o |
            bus.cache_wr_data_o | bus.mem_req_addr_o | bus.core_resp_data_o, 0);
      check("reset_hit_count", 32'(bus.hit_count_o), 0);
      check("reset_miss_count", 32'(bus.miss_count_o), 0);
      mreq_pend = 0; chk_ready = 0;
    end else begin
      check("idle_outputs_zero",
            32'((!bus.cache_rd_en_o && bus.cache_rd_addr_o != 0) ||
                (!bus.cache_wr_en_o && (bus.cache_wr_addr_o != 0 || bus.cache_wr_data_o != 0)) ||
                (!bus.mem_req_v_o && bus.mem_req_addr_o != 0) ||
                (!bus.core_resp_v_o && bus.core_resp_data_o != 0)), 0);
      if (mreq_pend) begin
        check("mem_req_v_hold", 32'(bus.mem_req_v_o), 1);
        check("mem_req_addr_hold", bus.mem_req_addr_o, maddr_prev);
      end
      mreq_pend  = bus.mem_req_v_o && !bus.mem_req_ready_i;
      maddr_prev = bus.mem_req_addr_o;
      if (bus.mem_req_v_o && bus.mem_req_ready_i) begin
        if (exp_maddr.size() == 0) check("mem_req_unexpected", 1, 0);
        else begin ea = exp_maddr.pop_front(); check("mem_req_addr", bus.mem_req_addr_o, ea); end
      end
      if (bus.cache_wr_en_o) begin
        if (exp_wr.size() == 0) check("cache_wr_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          check("cache_wr_addr", bus.cache_wr_addr_o, w.addr);
          check("cache_wr_data", bus.cache_wr_data_o, w.data);
        end
      end
      if (chk_ready) begin
        check("ready_after_resp", 32'(bus.core_ready_o), 1);
        chk_ready = 0;
      end
      if (bus.core_resp_v_o) begin
        if (exp_resp.size() == 0) check("core_resp_unexpected", 1, 0);
        else begin
          r = exp_resp.pop_front();
          check("core_resp_data", bus.core_resp_data_o, r.data);
          check("core_resp_cycle", 32'(cyc), 32'(r.cyc));
          check("hit_count", 32'(bus.hit_count_o), 32'(r.hits));
          check("miss_count", 32'(bus.miss_count_o), 32'(r.misses));
          chk_ready = 1;
        end
      end
    end
    rst_prev = reset_i;
    if (reset_i) begin exp_resp.delete(); exp_wr.delete(); exp_maddr.delete(); end
  end

  task automatic do_reset();
    bus.core_req_v_i = 0;
    reset_i = 1;
    @(negedge clk);
    reset_i = 0; m_hits = 0; m_misses = 0;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.core_ready_o && k < 50) begin @(negedge clk); k++; end
    if (!bus.core_ready_o) begin
      n_drv_fail++; $display("FAIL wait_ready: core_ready_o still 0 after %0d cycles", k);
      do_reset();
    end
  endtask

  // Plans one request, records the expected traffic, then drives it.
  task automatic run_txn(input logic [31:0] addr, input bit hit, input int stalls,
                         input int rd, input int sd, input bit spur);
    logic [31:0] a, md;
    resp_t r; wr_t w;
    int c, k;
    a = addr & ~32'h3;
    wait_ready();
    c = cyc;
    p_hit = hit; p_stalls = stalls; p_rd = rd; p_sd = sd; p_spur = spur;
    if (hit) begin
      p_hdata = cache_m[a];
      if (m_hits < CMAX) m_hits++;
      r.data = cache_m[a]; r.cyc = c + 2 + stalls;
    end else begin
      if (!memory_m.exists(a)) memory_m[a] = $urandom;
      md = memory_m[a]; p_mdata = md;
      if (m_misses < CMAX) m_misses++;
      exp_maddr.push_back(a);
      w.addr = a; w.data = md; exp_wr.push_back(w);
      r.data = md; r.cyc = c + 5 + stalls + rd + sd;
      cache_m[a] = md;
      memory_m[a] = $urandom;
    end
    r.hits = m_hits; r.misses = m_misses;
    exp_resp.push_back(r);
    bus.core_req_v_i = 1; bus.core_addr_i = addr;
    @(negedge clk);
    k = 0;
    while (exp_resp.size() != 0 && k < 300) begin
      // Junk requests while busy must be ignored; drop before IDLE returns.
      if (bus.core_resp_v_o) bus.core_req_v_i = 0;
      else begin bus.core_req_v_i = 1'($urandom % 2); bus.core_addr_i = $urandom; end
      @(negedge clk); k++;
    end
    bus.core_req_v_i = 0;
    if (exp_resp.size() != 0) begin
      n_drv_fail++; $display("FAIL resp_timeout: no core response after %0d cycles", k);
      do_reset();
    end
  endtask

  // Miss to addr, reset while waiting for memory; the response lands after reset.
  task automatic reset_mid(input logic [31:0] addr);
    logic [31:0] a;
    a = addr & ~32'h3;
    wait_ready();
    p_hit = 0; p_stalls = 0; p_rd = 0; p_sd = 5; p_spur = 0; p_mdata = 32'hBAD0BAD0;
    exp_maddr.push_back(a);
    bus.core_req_v_i = 1; bus.core_addr_i = addr;
    @(negedge clk); bus.core_req_v_i = 0;
    repeat (3) @(negedge clk);
    do_reset();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ad;
    bit h;
    bus.core_req_v_i = 0; bus.core_addr_i = '0;
    reset_i = 1;
    repeat (2) @(negedge clk);
    reset_i = 0;
    @(negedge clk);

    memory_m[32'h40] = 32'hDEADBEEF;
    run_txn(32'h40, 0, 0, 0, 2, 0);       // cold miss
    run_txn(32'h40, 1, 0, 0, 0, 0);       // repeat read hits
    run_txn(32'h43, 0, 0, 0, 1, 0);       // unaligned miss
    run_txn(32'h80, 0, 1, 4, 0, 1);       // memory stalls 4 cycles, spurious response
    reset_mid(32'hC0);
    for (int i = 0; i < 5; i++) run_txn(32'h40 + 32'($urandom_range(0, 3)), 1, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ad = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      h  = cache_m.exists(ad & ~32'h3) && ($urandom % 2 == 1);
      run_txn(ad, h, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom % 2));
    end

    repeat (3) @(negedge clk);
    if (exp_maddr.size() != 0 || exp_wr.size() != 0) begin
      n_drv_fail++;
      $display("FAIL leftover_expectations: mem_req %0d cache_wr %0d still pending",
               exp_maddr.size(), exp_wr.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks + n_drv_fail);
    $finish;
  end
endmodule
